// File: rtl/seu_mon_pkg.sv
// Shared types and helpers for the SEU count monitor: FSM encoding and saturating add.
package seu_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_HOLD = 2'd2,
        ST_CLR  = 2'd3
    } state_e;

    // Saturating add of two values interpreted as width-bit unsigned numbers (width <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (33'd1 << width) - 33'd1;
        return (sum > max) ? max[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/seu_count_monitor_sat_acc.sv
// Saturating accumulator; sum is the saturated next value (acc + add) before any clear.
module seu_sat_acc
    import seu_mon_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic [W-1:0] add,
    output logic [W-1:0] sum
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [31:0]  sum_wide;

    always_comb begin
        sum_wide = sat_add(32'(acc_q), 32'(add), W);
        sum      = W'(sum_wide);
        acc_d    = clr ? '0 : sum;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/seu_count_monitor.sv
// Turns a wrapping upstream SEU counter into a saturating total with a windowed rate alarm,
// a snapshot-read handshake and an upstream clear command.
//
//   state | meaning
//   IDLE  | waiting for rd_req (priority) or clr_req
//   SNAP  | latch total+delta into rd_data, restart total
//   HOLD  | rd_valid high until rd_ack
//   CLR   | seu_count_rst high, delta suppressed, last_count reloads 0
module seu_count_monitor
    import seu_mon_pkg::*;
#(
    parameter int unsigned SEUCNTWIDTH = 8,
    parameter int unsigned TOTALWIDTH  = 16,
    parameter int unsigned WINDOW_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [SEUCNTWIDTH-1:0] seu_count,
    output logic                   seu_count_rst,
    input  logic [SEUCNTWIDTH-1:0] rate_threshold,
    output logic                   alarm,
    input  logic                   alarm_clr,
    input  logic                   rd_req,
    output logic                   rd_valid,
    output logic [TOTALWIDTH-1:0]  rd_data,
    input  logic                   rd_ack,
    input  logic                   clr_req,
    output logic                   busy
);

    state_e                  state_q, state_d;
    logic [SEUCNTWIDTH-1:0]  last_count_q, last_count_d;
    logic [SEUCNTWIDTH-1:0]  delta;
    logic [WINDOW_LOG2-1:0]  win_cnt_q, win_cnt_d;
    logic                    win_end;
    logic                    alarm_q, alarm_d;
    logic                    alarm_set;
    logic                    rd_valid_q, rd_valid_d;
    logic [TOTALWIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    seu_count_rst_q, seu_count_rst_d;
    logic                    in_clr;
    logic                    in_snap;
    logic [TOTALWIDTH-1:0]   total_sum;
    logic [SEUCNTWIDTH-1:0]  win_sum;

    // Modulo subtraction makes an upstream wrap (all-ones -> 0) count as one event.
    always_comb begin
        in_clr       = (state_q == ST_CLR);
        in_snap      = (state_q == ST_SNAP);
        delta        = in_clr ? '0 : (seu_count - last_count_q);
        last_count_d = in_clr ? '0 : seu_count;
        win_cnt_d    = win_cnt_q + 1'b1;
        win_end      = &win_cnt_q;
    end

    seu_sat_acc #(.W(TOTALWIDTH)) u_total (
        .clk  (clk),
        .rstn (rstn),
        .clr  (in_snap),
        .add  (TOTALWIDTH'(delta)),
        .sum  (total_sum)
    );

    seu_sat_acc #(.W(SEUCNTWIDTH)) u_win_ev (
        .clk  (clk),
        .rstn (rstn),
        .clr  (win_end),
        .add  (delta),
        .sum  (win_sum)
    );

    // A set on the last window cycle beats a simultaneous alarm_clr.
    always_comb begin
        alarm_set = win_end && (rate_threshold != '0) && (win_sum >= rate_threshold);
        alarm_d   = alarm_q;
        if (alarm_clr) begin
            alarm_d = 1'b0;
        end
        if (alarm_set) begin
            alarm_d = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    state_d = ST_SNAP;
                end else if (clr_req) begin
                    state_d = ST_CLR;
                end
            end
            ST_SNAP: begin
                rd_data_d  = total_sum;
                rd_valid_d = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (rd_ack) begin
                    rd_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_CLR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        seu_count_rst_d = (state_d == ST_CLR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            last_count_q    <= '0;
            win_cnt_q       <= '0;
            alarm_q         <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_data_q       <= '0;
            seu_count_rst_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_count_q    <= last_count_d;
            win_cnt_q       <= win_cnt_d;
            alarm_q         <= alarm_d;
            rd_valid_q      <= rd_valid_d;
            rd_data_q       <= rd_data_d;
            seu_count_rst_q <= seu_count_rst_d;
        end
    end

    assign seu_count_rst = seu_count_rst_q;
    assign alarm         = alarm_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
